// File: rtl/fp_div_seq.sv
// Iterative IEEE-754 single-precision divider z = a / b, one quotient bit per cycle.
// Start/busy/done handshake; rounding modes and status layout shared with fp_mul.
module fp_div_seq #(
    parameter logic [2:0] round = 3'd0  // IEEE_near
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] z,
    output logic [7:0]  status
);

    localparam logic [2:0] IEEE_near = 3'd0;
    localparam logic [2:0] IEEE_zero = 3'd1;
    localparam logic [2:0] IEEE_pinf = 3'd2;
    localparam logic [2:0] IEEE_ninf = 3'd3;
    localparam logic [2:0] near_up   = 3'd4;
    localparam logic [2:0] away_zero = 3'd5;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [31:0] a_r, b_r;
    logic [25:0] rem;
    logic [25:0] q;
    logic [25:0] divisor;
    logic [25:0] rem_diff;
    logic        rem_ge;

    assign divisor  = {2'b00, 1'b1, b_r[22:0]};
    assign rem_ge   = (rem >= divisor);
    assign rem_diff = rem - divisor;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = DIV;
            DIV: begin
                busy = 1'b1;
                if (count == 5'd25) state_nxt = ROUND;
            end
            ROUND: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic                sign;
    logic                a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
    logic signed [9:0]   ediff, e_norm, e_rnd;
    logic [22:0]         mant;
    logic [23:0]         mant_r;
    logic                guard, sticky, inc;
    logic                away_of, away_uf;
    logic                dbz, inexact, huge, tiny, nan;
    logic [31:0]         z_nxt;
    logic [7:0]          status_nxt;

    always_comb begin
        sign   = a_r[31] ^ b_r[31];
        a_nan  = (a_r[30:23] == 8'hFF) && (a_r[22:0] != '0);
        a_inf  = (a_r[30:23] == 8'hFF) && (a_r[22:0] == '0);
        a_zero = (a_r[30:23] == 8'h00);
        b_nan  = (b_r[30:23] == 8'hFF) && (b_r[22:0] != '0);
        b_inf  = (b_r[30:23] == 8'hFF) && (b_r[22:0] == '0);
        b_zero = (b_r[30:23] == 8'h00);

        ediff = $signed({2'b00, a_r[30:23]}) - $signed({2'b00, b_r[30:23]});
        if (q[25]) begin
            mant   = q[24:2];
            guard  = q[1];
            sticky = q[0] | (rem != '0);
            e_norm = ediff + 10'sd127;
        end else begin
            mant   = q[23:1];
            guard  = q[0];
            sticky = (rem != '0);
            e_norm = ediff + 10'sd126;
        end

        case (round)
            IEEE_near: inc = guard & (sticky | mant[0]);
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = ~sign & (guard | sticky);
            IEEE_ninf: inc = sign & (guard | sticky);
            near_up:   inc = guard;
            away_zero: inc = guard | sticky;
            default:   inc = 1'b0;
        endcase

        // A carry out leaves mant_r[22:0] at zero, so only the exponent needs bumping.
        mant_r = {1'b0, mant} + {23'd0, inc};
        e_rnd  = e_norm + $signed({9'd0, mant_r[23]});

        away_of = (round == IEEE_near) || (round == near_up) || (round == away_zero) ||
                  ((round == IEEE_pinf) && !sign) || ((round == IEEE_ninf) && sign);
        away_uf = (round == away_zero) ||
                  ((round == IEEE_pinf) && !sign) || ((round == IEEE_ninf) && sign);

        dbz     = 1'b0;
        nan     = 1'b0;
        huge    = 1'b0;
        tiny    = 1'b0;
        inexact = guard | sticky;
        if (e_rnd > 10'sd254) begin
            huge    = 1'b1;
            inexact = 1'b1;
            z_nxt   = away_of ? {sign, 31'h7F800000} : {sign, 31'h7F7FFFFF};
        end else if (e_rnd < 10'sd1) begin
            tiny    = 1'b1;
            inexact = 1'b1;
            z_nxt   = away_uf ? {sign, 31'h00800000} : {sign, 31'h00000000};
        end else begin
            z_nxt   = {sign, e_rnd[7:0], mant_r[22:0]};
        end

        // Special operands override whatever the datapath produced.
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            z_nxt = 32'h7FC00000;
            nan   = 1'b1;
        end else if (b_zero && !a_inf) begin
            z_nxt = {sign, 31'h7F800000};
            dbz   = 1'b1;
        end else if (a_inf) begin
            z_nxt = {sign, 31'h7F800000};
        end else if (a_zero || b_inf) begin
            z_nxt = {sign, 31'h00000000};
        end
        if (a_nan || b_nan || a_inf || b_inf || a_zero || b_zero) begin
            inexact = 1'b0;
            huge    = 1'b0;
            tiny    = 1'b0;
        end

        status_nxt = {1'b0, dbz, inexact, huge, tiny, nan,
                      z_nxt[30:0] == 31'h7F800000, z_nxt[30:0] == 31'h00000000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            a_r    <= '0;
            b_r    <= '0;
            rem    <= '0;
            q      <= '0;
            z      <= '0;
            status <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    rem   <= {2'b00, 1'b1, a[22:0]};
                    q     <= '0;
                    count <= '0;
                end
                DIV: begin
                    if (rem_ge) begin
                        q   <= {q[24:0], 1'b1};
                        rem <= {rem_diff[24:0], 1'b0};
                    end else begin
                        q   <= {q[24:0], 1'b0};
                        rem <= {rem[24:0], 1'b0};
                    end
                    count <= count + 5'd1;
                end
                ROUND: begin
                    z      <= z_nxt;
                    status <= status_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: one DUT per rounding mode, all fed the same operands,
// checked against an arithmetic reference model of the division and rounding rules.
module tb_fp_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy_m   [6];
    logic        done_m   [6];
    logic [31:0] z_m      [6];
    logic [7:0]  status_m [6];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 6; m++) begin : g_dut
        fp_div_seq #(.round(3'(m))) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .a      (a),
            .b      (b),
            .busy   (busy_m[m]),
            .done   (done_m[m]),
            .z      (z_m[m]),
            .status (status_m[m])
        );
    end

    // Modes: 0 near-even, 1 toward zero, 2 toward +inf, 3 toward -inf, 4 near-up, 5 away from zero.
    function automatic logic [39:0] ref_div(input logic [31:0] x, input logic [31:0] y, input int mode);
        bit sg, xnan, xinf, xzero, ynan, yinf, yzero;
        bit g, s, inc, away, dbz, inex, huge, tiny, nan;
        int ex, ey, e;
        longint unsigned mx, my, num, qq, r, mant;
        logic [31:0] zz;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sg = x[31] ^ y[31];
        xnan = (ex == 255) && (x[22:0] != 0);  xinf = (ex == 255) && (x[22:0] == 0);  xzero = (ex == 0);
        ynan = (ey == 255) && (y[22:0] != 0);  yinf = (ey == 255) && (y[22:0] == 0);  yzero = (ey == 0);
        dbz = 0; inex = 0; huge = 0; tiny = 0; nan = 0;
        if (xnan || ynan || (xzero && yzero) || (xinf && yinf)) begin
            zz = 32'h7FC00000; nan = 1;
        end else if (yzero && !xinf) begin
            zz = {sg, 31'h7F800000}; dbz = 1;
        end else if (xinf) begin
            zz = {sg, 31'h7F800000};
        end else if (xzero || yinf) begin
            zz = {sg, 31'h0};
        end else begin
            mx  = 64'(x[22:0]) + (64'd1 << 23);
            my  = 64'(y[22:0]) + (64'd1 << 23);
            num = mx << 25;
            qq  = num / my;
            r   = num % my;
            if (qq >= (64'd1 << 25)) begin
                mant = (qq >> 2) & 64'h7FFFFF; g = qq[1]; s = qq[0] || (r != 0); e = ex - ey + 127;
            end else begin
                mant = (qq >> 1) & 64'h7FFFFF; g = qq[0]; s = (r != 0); e = ex - ey + 126;
            end
            case (mode)
                0:       inc = g && (s || mant[0]);
                1:       inc = 0;
                2:       inc = !sg && (g || s);
                3:       inc = sg && (g || s);
                4:       inc = g;
                default: inc = g || s;
            endcase
            mant = mant + 64'(inc);
            if (mant == (64'd1 << 23)) begin
                mant = 0;
                e    = e + 1;
            end
            inex = g || s;
            if (e > 254) begin
                huge = 1; inex = 1;
                away = (mode == 0) || (mode == 4) || (mode == 5) || (mode == 2 && !sg) || (mode == 3 && sg);
                zz   = away ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
            end else if (e < 1) begin
                tiny = 1; inex = 1;
                away = (mode == 5) || (mode == 2 && !sg) || (mode == 3 && sg);
                zz   = away ? {sg, 31'h00800000} : {sg, 31'h0};
            end else begin
                zz = {sg, 8'(e), 23'(mant)};
            end
        end
        return {zz, 1'b0, dbz, inex, huge, tiny, nan, zz[30:0] == 31'h7F800000, zz[30:0] == 31'h0};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 15);
        case (k)
            0:       v[30:0]  = '0;
            1:       v[30:0]  = 31'h7F800000;
            2:       v[30:23] = 8'hFF;
            3:       v[30:23] = 8'h00;
            4, 5:    ;
            default: v[30:23] = 8'(97 + $urandom_range(0, 60));
        endcase
        return v;
    endfunction

    // Issues one operation, returns the cycle (counting the start cycle as 1) in which done rose.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int glitch_at,
                         output int lat, output bit busy_seen, output bit pulse_ok);
        a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_seen = busy_m[0];
        while (!done_m[0] && lat < 60) begin
            if (lat == glitch_at) begin
                start = 1'b1; a = 32'h3F800000; b = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        pulse_ok = !done_m[0];
    endtask

    task automatic check_all_modes(input string name, input logic [31:0] x, input logic [31:0] y);
        logic [39:0] exp_v;
        for (int m = 0; m < 6; m++) begin
            exp_v = ref_div(x, y, m);
            vectors++;
            if ({z_m[m], status_m[m]} !== exp_v) begin
                miscompares++;
                $display("FAIL %s mode%0d a=%h b=%h: got z=%h st=%h, expected z=%h st=%h",
                         name, m, x, y, z_m[m], status_m[m], exp_v[39:8], exp_v[7:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int m = 0; m < 6; m++) begin
            vectors++;
            if ({busy_m[m], done_m[m], z_m[m], status_m[m]} !== 42'd0) begin
                miscompares++;
                $display("FAIL reset mode%0d: got busy=%b done=%b z=%h st=%h, expected all 0",
                         m, busy_m[m], done_m[m], z_m[m], status_m[m]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit bs, po;
        do_op(32'h40C00000, 32'h40000000, 0, lat, bs, po);
        vectors++;
        if (lat !== 28) begin miscompares++; $display("FAIL latency: got %0d, expected 28", lat); end
        vectors++;
        if (bs !== 1'b1) begin miscompares++; $display("FAIL busy_after_start: got %b, expected 1", bs); end
        vectors++;
        if (po !== 1'b1) begin miscompares++; $display("FAIL done_pulse_width: done still high, expected one cycle"); end
        vectors++;
        if (busy_m[0] !== 1'b0) begin miscompares++; $display("FAIL busy_idle: got %b, expected 0", busy_m[0]); end
        vectors++;
        if (z_m[0] !== 32'h40400000 || status_m[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL six_div_two: got z=%h st=%h, expected z=40400000 st=00", z_m[0], status_m[0]);
        end
        check_all_modes("six_div_two", 32'h40C00000, 32'h40000000);
    endtask

    task automatic test_one_third();
        int lat; bit bs, po;
        do_op(32'h3F800000, 32'h40400000, 0, lat, bs, po);
        vectors++;
        if (z_m[0] !== 32'h3EAAAAAB || status_m[0] !== 8'h20) begin
            miscompares++;
            $display("FAIL third_near: got z=%h st=%h, expected z=3EAAAAAB st=20", z_m[0], status_m[0]);
        end
        vectors++;
        if (z_m[1] !== 32'h3EAAAAAA) begin
            miscompares++;
            $display("FAIL third_zero: got z=%h, expected z=3EAAAAAA", z_m[1]);
        end
        check_all_modes("one_third", 32'h3F800000, 32'h40400000);
    endtask

    task automatic test_div_zero();
        int lat; bit bs, po;
        do_op(32'h40000000, 32'h00000000, 0, lat, bs, po);
        vectors++;
        if (lat !== 28 || z_m[0] !== 32'h7F800000 || status_m[0] !== 8'h42) begin
            miscompares++;
            $display("FAIL two_div_zero: got lat=%0d z=%h st=%h, expected lat=28 z=7F800000 st=42",
                     lat, z_m[0], status_m[0]);
        end
        do_op(32'h00000000, 32'h00000000, 0, lat, bs, po);
        vectors++;
        if (lat !== 28 || z_m[0] !== 32'h7FC00000 || status_m[0] !== 8'h04) begin
            miscompares++;
            $display("FAIL zero_div_zero: got lat=%0d z=%h st=%h, expected lat=28 z=7FC00000 st=04",
                     lat, z_m[0], status_m[0]);
        end
    endtask

    task automatic test_overflow_underflow();
        int lat; bit bs, po;
        do_op(32'h7F000000, 32'h00800000, 0, lat, bs, po);
        vectors++;
        if (z_m[0] !== 32'h7F800000 || status_m[0] !== 8'h32) begin
            miscompares++;
            $display("FAIL overflow_near: got z=%h st=%h, expected z=7F800000 st=32", z_m[0], status_m[0]);
        end
        vectors++;
        if (z_m[1] !== 32'h7F7FFFFF || status_m[1] !== 8'h30) begin
            miscompares++;
            $display("FAIL overflow_zero: got z=%h st=%h, expected z=7F7FFFFF st=30", z_m[1], status_m[1]);
        end
        check_all_modes("overflow", 32'h7F000000, 32'h00800000);
        do_op(32'h00800000, 32'h7F000000, 0, lat, bs, po);
        vectors++;
        if (z_m[0] !== 32'h00000000 || status_m[0] !== 8'h29) begin
            miscompares++;
            $display("FAIL underflow_near: got z=%h st=%h, expected z=00000000 st=29", z_m[0], status_m[0]);
        end
        vectors++;
        if (z_m[2] !== 32'h00800000 || status_m[2] !== 8'h28) begin
            miscompares++;
            $display("FAIL underflow_pinf: got z=%h st=%h, expected z=00800000 st=28", z_m[2], status_m[2]);
        end
        check_all_modes("underflow", 32'h00800000, 32'h7F000000);
    endtask

    task automatic test_ignored_start();
        int lat, extra_done; bit bs, po;
        do_op(32'h40C00000, 32'h40000000, 5, lat, bs, po);
        vectors++;
        if (lat !== 28 || z_m[0] !== 32'h40400000) begin
            miscompares++;
            $display("FAIL ignored_start: got lat=%0d z=%h, expected lat=28 z=40400000", lat, z_m[0]);
        end
        extra_done = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done_m[0]) extra_done++;
        end
        vectors++;
        if (extra_done !== 0) begin
            miscompares++;
            $display("FAIL ignored_start_extra_done: got %0d done pulses, expected 0", extra_done);
        end
    endtask

    task automatic test_reset_mid();
        int lat, dones; bit bs, po;
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({busy_m[0], done_m[0], z_m[0], status_m[0]} !== 42'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b z=%h st=%h, expected all 0",
                     busy_m[0], done_m[0], z_m[0], status_m[0]);
        end
        dones = 0;
        repeat (35) begin
            @(posedge clk); #1;
            if (done_m[0]) dones++;
        end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("FAIL reset_mid_done: got %0d pulses, expected 0", dones); end
        do_op(32'h40C00000, 32'h40000000, 0, lat, bs, po);
        vectors++;
        if (lat !== 28 || z_m[0] !== 32'h40400000) begin
            miscompares++;
            $display("FAIL after_reset_op: got lat=%0d z=%h, expected lat=28 z=40400000", lat, z_m[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        int lat; bit bs, po;
        for (int i = 0; i < 60; i++) begin
            x = rand_fp();
            y = rand_fp();
            do_op(x, y, 0, lat, bs, po);
            vectors++;
            if (lat !== 28 || po !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_timing a=%h b=%h: got lat=%0d pulse_ok=%b, expected lat=28 pulse_ok=1",
                         x, y, lat, po);
            end
            check_all_modes("random", x, y);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_one_third();
        test_div_zero();
        test_overflow_underflow();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
